// File: rtl/sys_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sys_bus_pkg
//  Description : Shared definitions for the system-bus arbiter and the cache
//                controllers that drive it (direction codes, FSM states,
//                default memory wait-state count).
//  Revision    : 1.0  initial release
// ============================================================================
package sys_bus_pkg;

    // Transfer direction as carried on ReqRW / MemRW
    localparam logic c_READ  = 1'b1;
    localparam logic c_WRITE = 1'b0;

    // Memory access cycles after the strobe; the caches size their timeouts from this
    localparam int c_DEFAULT_WAITSTATES = 2;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arbState_t;

endpackage
`default_nettype wire

// File: rtl/sys_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Scans the pending vector
//                starting one past the previous owner and returns the first
//                pending requester as a one-hot vector.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
    import sys_bus_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int LGW  = 1
) (
    input  logic [NREQ-1:0] Pending,
    input  logic [LGW-1:0]  LastGrant,
    output logic [NREQ-1:0] Winner,
    output logic            Any
);

    logic [LGW:0]   w_sum;
    logic [LGW-1:0] w_idx;

    // Walk offsets 1..NREQ from the last owner so the last owner is checked last
    always_comb begin
        Winner = '0;
        Any    = 1'b0;
        w_sum  = '0;
        w_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            // LastGrant <= NREQ-1 and k <= NREQ, so one subtraction wraps it
            w_sum = {1'b0, LastGrant} + (LGW+1)'(k);
            if (w_sum >= (LGW+1)'(NREQ)) begin
                w_sum = w_sum - (LGW+1)'(NREQ);
            end
            w_idx = w_sum[LGW-1:0];
            if (!Any && Pending[w_idx]) begin
                Winner[w_idx] = 1'b1;
                Any           = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sys_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sys_bus_arbiter
//  Description : Shares the single system-memory port between NREQ cache
//                controllers. Latches one-cycle request strobes as pending
//                requests, grants round-robin, sequences the memory access
//                through a fixed wait-state count and returns a completion
//                pulse to the owner.
//  Revision    : 1.0  initial release
// ============================================================================
module sys_bus_arbiter
    import sys_bus_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int AW         = 32,
    parameter int WAITSTATES = c_DEFAULT_WAITSTATES
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NREQ-1:0]    ReqStrobe,
    input  logic [NREQ-1:0]    ReqRW,
    input  logic [NREQ*AW-1:0] ReqAddr,
    output logic [NREQ-1:0]    ReqDone,
    output logic [NREQ-1:0]    Grant,
    output logic               MemStrobe,
    output logic               MemRW,
    output logic [AW-1:0]      MemAddr,
    output logic               MemBusy
);

    localparam int LGW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(WAITSTATES) + 1;
    localparam logic [LGW-1:0] c_LAST_RESET = LGW'(NREQ - 1);

    arbState_t                 r_state;
    logic [NREQ-1:0]           r_pending;
    logic [NREQ-1:0]           r_latRW;
    logic [NREQ-1:0][AW-1:0]   r_latAddr;
    logic [NREQ-1:0]           r_grant;
    logic [LGW-1:0]            r_grantIdx;
    logic [LGW-1:0]            r_lastGrant;
    logic [NREQ-1:0]           r_reqDone;
    logic                      r_memStrobe;
    logic                      r_memRW;
    logic [AW-1:0]             r_memAddr;
    logic [CW-1:0]             r_count;

    logic [NREQ-1:0]           w_winner;
    logic                      w_any;
    logic [LGW-1:0]            w_winnerIdx;
    logic [NREQ-1:0]           w_clear;

    // The owner's pending bit retires in the DONE cycle
    assign w_clear = (r_state == ST_DONE) ? r_grant : '0;

    // Per-requester pending flag and request capture; a new strobe in the
    // owner's own DONE cycle re-arms the request instead of being lost
    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_req
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    r_pending[i] <= 1'b0;
                    r_latRW[i]   <= c_WRITE;
                    r_latAddr[i] <= '0;
                end else if (ReqStrobe[i] && (!r_pending[i] || w_clear[i])) begin
                    r_pending[i] <= 1'b1;
                    r_latRW[i]   <= ReqRW[i];
                    r_latAddr[i] <= ReqAddr[i*AW +: AW];
                end else if (w_clear[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    endgenerate

    rr_pick #(
        .NREQ      (NREQ),
        .LGW       (LGW)
    ) u_rrPick (
        .Pending   (r_pending),
        .LastGrant (r_lastGrant),
        .Winner    (w_winner),
        .Any       (w_any)
    );

    // One-hot winner to index, used to select the latched request and to
    // remember the owner for the next round-robin search
    always_comb begin
        w_winnerIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_winner[i]) begin
                w_winnerIdx = LGW'(i);
            end
        end
    end

    // Access sequencer with registered memory-side and completion outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_grantIdx  <= '0;
            r_lastGrant <= c_LAST_RESET;
            r_reqDone   <= '0;
            r_memStrobe <= 1'b0;
            r_memRW     <= c_WRITE;
            r_memAddr   <= '0;
            r_count     <= '0;
        end else begin
            r_memStrobe <= 1'b0;
            r_reqDone   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant     <= w_winner;
                        r_grantIdx  <= w_winnerIdx;
                        r_memStrobe <= 1'b1;
                        r_memRW     <= r_latRW[w_winnerIdx];
                        r_memAddr   <= r_latAddr[w_winnerIdx];
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_count <= CW'(WAITSTATES - 1);
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_count == '0) begin
                        r_reqDone <= r_grant;
                        r_state   <= ST_DONE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                ST_DONE: begin
                    r_grant     <= '0;
                    r_lastGrant <= r_grantIdx;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ReqDone   = r_reqDone;
    assign Grant     = r_grant;
    assign MemStrobe = r_memStrobe;
    assign MemRW     = r_memRW;
    assign MemAddr   = r_memAddr;
    assign MemBusy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sys_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sys_bus_arbiter
//  Description : Directed self-checking bench for sys_bus_arbiter (NREQ=2,
//                AW=32, WAITSTATES=2). Inputs change and outputs are observed
//                on the falling edge; "cycle c" is the c-th falling edge after
//                the strobe was driven.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sys_bus_arbiter;

    logic        Clk;
    logic        Reset;
    logic [1:0]  ReqStrobe;
    logic [1:0]  ReqRW;
    logic [63:0] ReqAddr;
    logic [1:0]  ReqDone;
    logic [1:0]  Grant;
    logic        MemStrobe;
    logic        MemRW;
    logic [31:0] MemAddr;
    logic        MemBusy;

    int total = 0;
    int bad   = 0;

    sys_bus_arbiter #(
        .NREQ       (2),
        .AW         (32),
        .WAITSTATES (2)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ReqStrobe  (ReqStrobe),
        .ReqRW      (ReqRW),
        .ReqAddr    (ReqAddr),
        .ReqDone    (ReqDone),
        .Grant      (Grant),
        .MemStrobe  (MemStrobe),
        .MemRW      (MemRW),
        .MemAddr    (MemAddr),
        .MemBusy    (MemBusy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic do_reset();
        Reset     = 1'b1;
        ReqStrobe = 2'b00;
        ReqRW     = 2'b00;
        ReqAddr   = '0;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        ReqStrobe = 2'b00;
        ReqRW     = 2'b00;
        ReqAddr   = '0;
        @(negedge Clk);
        @(negedge Clk);
        total++;
        if ({Grant, ReqDone, MemStrobe, MemRW, MemBusy} !== 7'b0 || MemAddr !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got Grant=%b ReqDone=%b MemStrobe=%b MemRW=%b MemBusy=%b MemAddr=%h, want all zero",
                     Grant, ReqDone, MemStrobe, MemRW, MemBusy, MemAddr);
        end
        Reset = 1'b0;
        @(negedge Clk);
        total++;
        if (MemBusy !== 1'b0 || Grant !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle: got MemBusy=%b Grant=%b want 0/00", MemBusy, Grant);
        end
    endtask

    task automatic test_single_read();
        logic [1:0] expDone, expGrant;
        logic       expStrobe, expBusy;
        do_reset();
        ReqStrobe = 2'b01;
        ReqRW     = 2'b01;
        ReqAddr   = {32'h0, 32'h100};
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            expStrobe = (c == 2);
            expDone   = (c == 5) ? 2'b01 : 2'b00;
            expBusy   = (c >= 2 && c <= 5);
            expGrant  = expBusy ? 2'b01 : 2'b00;
            total++;
            if (MemStrobe !== expStrobe || ReqDone !== expDone || MemBusy !== expBusy || Grant !== expGrant) begin
                bad++;
                $display("FAIL single_read c=%0d: got strobe=%b done=%b busy=%b grant=%b want %b %b %b %b",
                         c, MemStrobe, ReqDone, MemBusy, Grant, expStrobe, expDone, expBusy, expGrant);
            end
            if (c == 2 || c == 6) begin
                total++;
                if (MemRW !== 1'b1 || MemAddr !== 32'h100) begin
                    bad++;
                    $display("FAIL single_read_addr c=%0d: got rw=%b addr=%h want 1 00000100", c, MemRW, MemAddr);
                end
            end
            if (c == 1) ReqStrobe = 2'b00;
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] expDone, expGrant;
        logic       expStrobe;
        do_reset();
        ReqStrobe = 2'b11;
        ReqRW     = 2'b01;
        ReqAddr   = {32'h300, 32'h100};
        for (int c = 1; c <= 12; c++) begin
            @(negedge Clk);
            expStrobe = (c == 2 || c == 7);
            expDone   = (c == 5) ? 2'b01 : (c == 10) ? 2'b10 : 2'b00;
            expGrant  = (c >= 2 && c <= 5) ? 2'b01 : (c >= 7 && c <= 10) ? 2'b10 : 2'b00;
            total++;
            if (MemStrobe !== expStrobe || ReqDone !== expDone || Grant !== expGrant) begin
                bad++;
                $display("FAIL simultaneous c=%0d: got strobe=%b done=%b grant=%b want %b %b %b",
                         c, MemStrobe, ReqDone, Grant, expStrobe, expDone, expGrant);
            end
            if (c == 7) begin
                total++;
                if (MemRW !== 1'b0 || MemAddr !== 32'h300) begin
                    bad++;
                    $display("FAIL simultaneous_req1_addr: got rw=%b addr=%h want 0 00000300", MemRW, MemAddr);
                end
            end
            if (c == 1) ReqStrobe = 2'b00;
        end
    endtask

    // Runs straight after test_simultaneous, so requester 1 was the last owner
    task automatic test_alternate();
        logic [1:0] expDone;
        int         nDone;
        nDone     = 0;
        ReqStrobe = 2'b11;
        ReqRW     = 2'b00;
        ReqAddr   = {32'h440, 32'h400};
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clk);
            if (c <= 35 && c % 5 == 0)
                expDone = ((c / 5) % 2 == 1) ? 2'b01 : 2'b10;
            else
                expDone = 2'b00;
            if (ReqDone !== 2'b00) nDone++;
            total++;
            if (ReqDone !== expDone) begin
                bad++;
                $display("FAIL alternate c=%0d: got done=%b want %b", c, ReqDone, expDone);
            end
            if (c == 29) ReqStrobe = 2'b00;
        end
        total++;
        if (nDone != 7 || MemBusy !== 1'b0) begin
            bad++;
            $display("FAIL alternate_count: got %0d pulses busy=%b want 7 pulses busy=0", nDone, MemBusy);
        end
    endtask

    task automatic test_duplicate();
        logic [1:0] expDone;
        do_reset();
        ReqStrobe = 2'b10;
        ReqRW     = 2'b11;
        ReqAddr   = {32'h300, 32'h0};
        for (int c = 1; c <= 14; c++) begin
            @(negedge Clk);
            expDone = (c == 5) ? 2'b10 : (c == 10) ? 2'b01 : 2'b00;
            total++;
            if (ReqDone !== expDone) begin
                bad++;
                $display("FAIL duplicate_done c=%0d: got %b want %b", c, ReqDone, expDone);
            end
            if (c == 7) begin
                total++;
                if (MemStrobe !== 1'b1 || MemRW !== 1'b1 || MemAddr !== 32'h100) begin
                    bad++;
                    $display("FAIL duplicate_addr: got strobe=%b rw=%b addr=%h want 1 1 00000100",
                             MemStrobe, MemRW, MemAddr);
                end
            end
            if (c == 1) begin
                ReqStrobe = 2'b01;
                ReqRW     = 2'b01;
                ReqAddr   = {32'h0, 32'h100};
            end else if (c == 3) begin
                ReqStrobe = 2'b01;
                ReqRW     = 2'b00;
                ReqAddr   = {32'h0, 32'h200};
            end else begin
                ReqStrobe = 2'b00;
            end
        end
    endtask

    task automatic test_done_strobe();
        logic [1:0] expDone;
        int         nDone;
        nDone = 0;
        do_reset();
        ReqStrobe = 2'b01;
        ReqRW     = 2'b01;
        ReqAddr   = {32'h0, 32'h100};
        for (int c = 1; c <= 14; c++) begin
            @(negedge Clk);
            expDone = (c == 5 || c == 10) ? 2'b01 : 2'b00;
            if (ReqDone !== 2'b00) nDone++;
            total++;
            if (ReqDone !== expDone) begin
                bad++;
                $display("FAIL done_strobe c=%0d: got done=%b want %b", c, ReqDone, expDone);
            end
            if (c == 7) begin
                total++;
                if (MemStrobe !== 1'b1 || MemRW !== 1'b0 || MemAddr !== 32'h140) begin
                    bad++;
                    $display("FAIL done_strobe_reissue: got strobe=%b rw=%b addr=%h want 1 0 00000140",
                             MemStrobe, MemRW, MemAddr);
                end
            end
            if (c == 5) begin
                ReqStrobe = 2'b01;
                ReqRW     = 2'b00;
                ReqAddr   = {32'h0, 32'h140};
            end else begin
                ReqStrobe = 2'b00;
            end
        end
        total++;
        if (nDone != 2) begin
            bad++;
            $display("FAIL done_strobe_count: got %0d pulses want 2", nDone);
        end
    endtask

    task automatic test_reset_mid();
        int nDone;
        nDone = 0;
        do_reset();
        ReqStrobe = 2'b01;
        ReqRW     = 2'b01;
        ReqAddr   = {32'h300, 32'h100};
        for (int c = 1; c <= 14; c++) begin
            @(negedge Clk);
            if (c == 3) begin
                total++;
                if (MemBusy !== 1'b1 || Grant !== 2'b01) begin
                    bad++;
                    $display("FAIL reset_mid_wait: got busy=%b grant=%b want 1 01", MemBusy, Grant);
                end
            end
            if (c == 4) begin
                total++;
                if ({Grant, ReqDone, MemStrobe, MemRW, MemBusy} !== 7'b0 || MemAddr !== 32'h0) begin
                    bad++;
                    $display("FAIL reset_mid_values: got Grant=%b ReqDone=%b MemStrobe=%b MemRW=%b MemBusy=%b MemAddr=%h want all zero",
                             Grant, ReqDone, MemStrobe, MemRW, MemBusy, MemAddr);
                end
            end
            if (c >= 5) begin
                if (ReqDone !== 2'b00) nDone++;
                total++;
                if (MemBusy !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_mid_idle c=%0d: got busy=%b want 0", c, MemBusy);
                end
            end
            ReqStrobe = (c == 1) ? 2'b10 : 2'b00;
            Reset     = (c == 3);
        end
        total++;
        if (nDone != 0) begin
            bad++;
            $display("FAIL reset_mid_nodone: got %0d pulses want 0", nDone);
        end
        ReqStrobe = 2'b10;
        ReqRW     = 2'b00;
        ReqAddr   = {32'h380, 32'h0};
        for (int c = 1; c <= 6; c++) begin
            @(negedge Clk);
            if (c == 2) begin
                total++;
                if (MemStrobe !== 1'b1 || MemAddr !== 32'h380 || Grant !== 2'b10) begin
                    bad++;
                    $display("FAIL reset_mid_restart: got strobe=%b addr=%h grant=%b want 1 00000380 10",
                             MemStrobe, MemAddr, Grant);
                end
            end
            if (c == 5) begin
                total++;
                if (ReqDone !== 2'b10) begin
                    bad++;
                    $display("FAIL reset_mid_restart_done: got %b want 10", ReqDone);
                end
            end
            ReqStrobe = 2'b00;
        end
    endtask

    initial begin
        Reset     = 1'b1;
        ReqStrobe = 2'b00;
        ReqRW     = 2'b00;
        ReqAddr   = '0;
        test_reset();
        test_single_read();
        test_simultaneous();
        test_alternate();
        test_duplicate();
        test_done_strobe();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sys_bus_arbiter.md
# sys_bus_arbiter

Shares the single system-memory port between several cache controllers (instruction and data cache, NREQ=2 by default). Each controller's one-cycle system strobe is latched as a pending request. The block grants the port round-robin, drives the memory strobe, address and direction, and counts the fixed memory wait states. It returns a one-cycle completion pulse to the granted requester and drives a one-hot grant that steers the external data muxes.

## Interface
- NREQ, 2, number of requesters (≥2)
- AW, 32, address width
- WAITSTATES, 2, memory access cycles after strobe (≥1)

- Clk  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- ReqStrobe  in  NREQ  per-requester one-cycle request pulse
- ReqRW  in  NREQ  direction, sampled with strobe; READ=1, WRITE=0
- ReqAddr  in  NREQ*AW  flattened addresses, slice i = requester i, sampled with strobe
- ReqDone  out  NREQ  one-cycle completion pulse to the granted requester
- Grant  out  NREQ  one-hot owner of the memory port, 0 when idle
- MemStrobe  out  1  one-cycle memory access strobe
- MemRW  out  1  direction of current access
- MemAddr  out  AW  address of current access
- MemBusy  out  1  high whenever state ≠ IDLE

## Operation
- Per requester: Pending bit, latched RW and Addr, loaded when ReqStrobe[i]=1.
- A strobe while Pending[i] is already set is ignored. The original request is kept.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: if any Pending, pick the winner round-robin and register Grant, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: MemStrobe=1, load the counter with WAITSTATES-1, go to WAIT.
  - WAIT: if the counter is 0, go to DONE. Otherwise decrement.
  - DONE: ReqDone[g]=1, clear Pending[g], LastGrant←g, go to IDLE. Grant is held through DONE.
- Round-robin: search starts at LastGrant+1 modulo NREQ. The reset value of LastGrant is NREQ-1, so requester 0 wins the first tie.
- MemRW and MemAddr come from the granted requester's latched copy. They are stable from ISSUE through DONE and hold their last value in IDLE.
- Counter width is $clog2(WAITSTATES)+1. It never wraps.

## Timing
- Reset values: Grant=0, ReqDone=0, MemStrobe=0, MemRW=0, MemAddr=0, MemBusy=0, all Pending=0, state IDLE, LastGrant=NREQ-1.
- Uncontended latency, strobe at cycle 0:
  - Pending set at cycle 1
  - ISSUE at cycle 2
  - WAIT for cycles 3..2+WAITSTATES
  - DONE (ReqDone) at cycle 3+WAITSTATES, i.e. cycle 5 at the default setting
- Back-to-back: IDLE lasts at least one cycle between transactions. The occupancy per transaction is WAITSTATES+3 cycles.
- Simultaneous strobes: all requests latch in the same cycle, and they are served in round-robin order.
- A strobe from requester g during its own DONE cycle is a set and clear together. Set wins, and the new request is pending.
- Reset mid-transaction: the next cycle shows reset values. No ReqDone is issued and pending requests are dropped.

## Structure
- Shared package sys_bus_pkg holds:
  - the READ/WRITE constants
  - the state enum (4 values, 2 bits)
  - the default WAITSTATES value shared with the cache controllers
- Sub-module rr_pick: combinational round-robin picker. Inputs are Pending[NREQ] and LastGrant. Outputs are one-hot Winner and Any.

## Test plan
- Single read from requester 0: ReqStrobe=01, ReqRW=01, addr 0x100, WAITSTATES=2.
  - MemStrobe at cycle 2 with MemRW=1, MemAddr=0x100.
  - ReqDone=01 at cycle 5, MemBusy low at cycle 6.
- Simultaneous strobes from both requesters after reset: requester 0 served first (ReqDone=01 at cycle 5), requester 1 MemStrobe at cycle 7, ReqDone=10 at cycle 10.
- Requester 1 repeatedly re-requesting while requester 0 is pending: grants strictly alternate, with no requester served twice in a row.
- Duplicate ReqStrobe[0] with addr 0x200 while pending on 0x100: the access uses 0x100, and only one ReqDone is produced.
- Strobe during own DONE: the second transaction issues, and two ReqDone pulses are seen in total.
- Reset asserted in WAIT: all outputs are 0 the next cycle, no ReqDone, and the arbiter is idle afterwards until a new strobe arrives.
